instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 29 ++
 rtl/instr_fetch_next_pc_sel.sv | 55 +++++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared definitions for the MIPS instruction fetch stage
//
// Purpose: default widths, reset PC, opcode values shared with the control
// unit, and the fetch FSM state type.
// Ports: none (package).
package instr_fetch_pkg;

  localparam int          ADDR_WIDTH_DEF  = 32;
  localparam int          DATA_WIDTH_DEF  = 32;
  localparam int          OP_WIDTH_DEF    = 6;
  localparam int          FUNCT_WIDTH_DEF = 6;
  localparam int          REG_WIDTH       = 5;
  localparam int          IMM_WIDTH       = 16;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// rtl/instr_fetch_next_pc_sel.sv - next PC computation for the fetch stage
//
// Purpose: combinational pc+4, branch target, jump target and the
// redirect > jump > taken-branch > pc+4 priority mux.
// Ports:
//   i_pc            address of the presented instruction
//   i_target        instr[25:0] (jump index; [15:0] is the branch immediate)
//   i_branch/i_zero branch taken when both set
//   i_jump          jump flag
//   i_redirect      redirect request
//   i_redirect_pc   redirect target (low two bits ignored)
//   o_redirect_tgt  word-aligned redirect target
//   o_next_pc       selected next PC
module next_pc_sel
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH_P = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH_P-1:0] i_pc,
  input  logic [25:0]             i_target,
  input  logic                    i_branch,
  input  logic                    i_zero,
  input  logic                    i_jump,
  input  logic                    i_redirect,
  input  logic [ADDR_WIDTH_P-1:0] i_redirect_pc,
  output logic [ADDR_WIDTH_P-1:0] o_redirect_tgt,
  output logic [ADDR_WIDTH_P-1:0] o_next_pc
);

  logic [ADDR_WIDTH_P-1:0] w_pc_plus4;
  logic [ADDR_WIDTH_P-1:0] w_br_off;
  logic [ADDR_WIDTH_P-1:0] w_br_tgt;
  logic [ADDR_WIDTH_P-1:0] w_jmp_tgt;

  // All additions wrap modulo 2^ADDR_WIDTH_P.
  assign w_pc_plus4 = i_pc + ADDR_WIDTH_P'(4);
  assign w_br_off   = {{(ADDR_WIDTH_P-18){i_target[15]}}, i_target[15:0], 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;
  // Jump stays within the 256 MB region of the delay-slot-free pc+4.
  assign w_jmp_tgt  = {w_pc_plus4[ADDR_WIDTH_P-1:28], i_target, 2'b00};

  assign o_redirect_tgt = i_redirect_pc & ~ADDR_WIDTH_P'(3);

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_redirect) begin
      o_next_pc = o_redirect_tgt;
    end else if (i_jump) begin
      o_next_pc = w_jmp_tgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_tgt;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, instruction memory fetch and issue handshake
//
// Purpose: holds the PC, fetches one word per req/ack transaction, presents it
// with valid/ready plus decoded fields, and advances the PC at retirement.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   o_imem_req, o_imem_addr           fetch request and word address
//   i_imem_ack, i_imem_rdata          fetch response
//   o_instr_valid, i_instr_ready      issue handshake
//   o_instr, o_opcode, o_function,
//   o_rs, o_rt, o_rd, o_imm, o_pc     presented instruction and its fields
//   i_branch, i_zero, i_jump          retirement flow-control flags
//   i_redirect, i_redirect_pc         forced refetch target
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH_P  = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH_P  = DATA_WIDTH_DEF,
  parameter int                    OP_WIDTH_P    = OP_WIDTH_DEF,
  parameter int                    FUNCT_WIDTH_P = FUNCT_WIDTH_DEF,
  parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P  = RESET_PC_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_imem_req,
  output logic [ADDR_WIDTH_P-1:0]  o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [DATA_WIDTH_P-1:0]  i_imem_rdata,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  output logic [DATA_WIDTH_P-1:0]  o_instr,
  output logic [OP_WIDTH_P-1:0]    o_opcode,
  output logic [FUNCT_WIDTH_P-1:0] o_function,
  output logic [REG_WIDTH-1:0]     o_rs,
  output logic [REG_WIDTH-1:0]     o_rt,
  output logic [REG_WIDTH-1:0]     o_rd,
  output logic [IMM_WIDTH-1:0]     o_imm,
  output logic [ADDR_WIDTH_P-1:0]  o_pc,
  input  logic                     i_branch,
  input  logic                     i_zero,
  input  logic                     i_jump,
  input  logic                     i_redirect,
  input  logic [ADDR_WIDTH_P-1:0]  i_redirect_pc
);

  fetch_state_e            r_state;
  logic [ADDR_WIDTH_P-1:0] r_pc;
  logic [ADDR_WIDTH_P-1:0] r_addr;
  logic [ADDR_WIDTH_P-1:0] r_redir_pc;
  logic [DATA_WIDTH_P-1:0] r_instr;
  logic                    r_req;
  logic                    r_valid;

  logic [ADDR_WIDTH_P-1:0] w_next_pc;
  logic [ADDR_WIDTH_P-1:0] w_redir_tgt;
  logic [ADDR_WIDTH_P-1:0] w_drain_tgt;

  next_pc_sel #(
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) u_next_pc_sel (
    .i_pc           (r_pc),
    .i_target       (r_instr[25:0]),
    .i_branch       (i_branch),
    .i_zero         (i_zero),
    .i_jump         (i_jump),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .o_redirect_tgt (w_redir_tgt),
    .o_next_pc      (w_next_pc)
  );

  // A redirect arriving on the same cycle as the draining ack is the newest.
  assign w_drain_tgt = i_redirect ? w_redir_tgt : r_redir_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC_P;
      r_addr     <= RESET_PC_P;
      r_redir_pc <= RESET_PC_P;
      r_instr    <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
          if (i_redirect) begin
            r_pc   <= w_redir_tgt;
            r_addr <= w_redir_tgt;
          end else begin
            r_addr <= r_pc;
          end
        end
        ST_FETCH: begin
          if (i_imem_ack) begin
            if (i_redirect) begin
              // Returned word belongs to the abandoned path; refetch at once.
              r_pc   <= w_redir_tgt;
              r_addr <= w_redir_tgt;
            end else begin
              r_instr <= i_imem_rdata;
              r_req   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end else if (i_redirect) begin
            // Memory still owes us a word; keep req/addr until it arrives.
            r_redir_pc <= w_redir_tgt;
            r_state    <= ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          // w_next_pc already gives redirect priority over retirement.
          if (i_redirect || i_instr_ready) begin
            r_pc    <= w_next_pc;
            r_addr  <= w_next_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (i_imem_ack) begin
            r_pc    <= w_drain_tgt;
            r_addr  <= w_drain_tgt;
            r_state <= ST_FETCH;
          end else if (i_redirect) begin
            r_redir_pc <= w_redir_tgt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_pc          = r_pc;
  assign o_opcode      = r_instr[DATA_WIDTH_P-1 -: OP_WIDTH_P];
  assign o_function    = r_instr[FUNCT_WIDTH_P-1:0];
  assign o_rs          = r_instr[25:21];
  assign o_rt          = r_instr[20:16];
  assign o_rd          = r_instr[15:11];
  assign o_imm         = r_instr[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [5:0]  o_opcode;
  logic [5:0]  o_function;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [15:0] o_imm;
  logic [31:0] o_pc;
  logic        i_branch, i_zero, i_jump, i_redirect;
  logic [31:0] i_redirect_pc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_opcode      (o_opcode),
    .o_function    (o_function),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_imm         (o_imm),
    .o_pc          (o_pc),
    .i_branch      (i_branch),
    .i_zero        (i_zero),
    .i_jump        (i_jump),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_presented = 0;
  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  logic        m_presenting = 1'b0;
  logic [31:0] cur_pc = 32'h0;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  function automatic logic rbit(input int pct);
    return ($urandom % 100) < pct;
  endfunction

  // Architectural next PC: what the program counter must become after retiring.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic br, input logic z, input logic j);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (br && z) return p4 + 32'($signed(ins[15:0])) * 32'd4;
    return p4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, update the reference model, advance to next negedge.
  task automatic cyc(input logic ack, input logic rdy, input logic br, input logic z,
                     input logic j, input logic rd, input logic [31:0] rpc);
    logic [31:0] t;
    i_imem_ack    = ack;
    i_imem_rdata  = ack ? mem_at(o_imem_addr) : $urandom;
    i_instr_ready = rdy;
    i_branch      = br;
    i_zero        = z;
    i_jump        = j;
    i_redirect    = rd;
    i_redirect_pc = rpc;
    t = rpc & ~32'h3;
    if (rd) begin
      // Presented instruction is dropped, or the pending fetch is superseded.
      if (m_presenting) begin
        exp_q.push_back(t);
        m_presenting = 1'b0;
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(t);
      end
    end else if (m_presenting && rdy) begin
      exp_q.push_back(ref_next(cur_pc, mem_at(cur_pc), br, z, j));
      m_presenting = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_imem_ack = 1'b0; i_imem_rdata = 32'h0; i_instr_ready = 1'b0;
    i_branch = 1'b0; i_zero = 1'b0; i_jump = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
  endtask

  // Monitor: pops the expected PC whenever a new instruction is presented.
  initial begin : monitor
    logic        last_valid;
    logic [31:0] e, ei;
    last_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_valid = 1'b0;
        continue;
      end
      if (o_instr_valid && !last_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_issue_pc", o_pc, 32'hxxxx_xxxx);
        end else begin
          e  = exp_q.pop_front();
          ei = mem_at(e);
          cur_pc = e;
          m_presenting = 1'b1;
          n_presented++;
          chk("sb_pc", o_pc, e);
          chk("sb_instr", o_instr, ei);
          chk("sb_opcode", 32'(o_opcode), 32'(ei[31:26]));
          chk("sb_function", 32'(o_function), 32'(ei[5:0]));
          chk("sb_rs", 32'(o_rs), 32'(ei[25:21]));
          chk("sb_rt", 32'(o_rt), 32'(ei[20:16]));
          chk("sb_rd", 32'(o_rd), 32'(ei[15:11]));
          chk("sb_imm", 32'(o_imm), 32'(ei[15:0]));
        end
      end else if (o_instr_valid && last_valid) begin
        chk("hold_pc", o_pc, cur_pc);
        chk("hold_instr", o_instr, mem_at(cur_pc));
      end
      last_valid = o_instr_valid;
    end
  end

  initial begin : driver
    int          wait_cnt;
    int          dly;
    logic [31:0] held;
    logic        ack;
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = {OP_RTYPE, 20'd0, 6'h20};
    mem[1] = {OP_JUMP, 26'h40};
    mem[2] = {OP_BEQ, 10'd0, 16'hFFFF};
    mem[4] = {OP_BEQ, 10'd0, 16'h0003};
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_fields", {o_opcode, o_function, o_rs, o_rt, o_rd}, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("first_req", 32'(o_imem_req), 32'd1);
    chk("first_addr", o_imem_addr, 32'h0);
    chk("first_valid_low", 32'(o_instr_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("valid_cycle3", 32'(o_instr_valid), 32'd1);
    chk("function_20", 32'(o_function), 32'h20);
    chk("opcode_0", 32'(o_opcode), 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("seq_req", 32'(o_imem_req), 32'd1);
    chk("seq_addr", o_imem_addr, 32'h4);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("jump_addr", o_imem_addr, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'h0000_000B);
    chk("redirect_issue_addr", o_imem_addr, 32'h8);
    chk("redirect_issue_valid", 32'(o_instr_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("branch_back_addr", o_imem_addr, 32'h8);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("branch_nt_addr", o_imem_addr, 32'hC);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("branch_taken_addr", o_imem_addr, 32'h20);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("beq_zero_low_addr", o_imem_addr, 32'h14);

    for (int k = 0; k < 5; k++) begin
      chk("wait_req", 32'(o_imem_req), 32'd1);
      chk("wait_addr", o_imem_addr, 32'h14);
      chk("wait_valid", 32'(o_instr_valid), 32'd0);
      cyc(0, 1, 0, 0, 0, 0, 0);
    end
    chk("wait_req6", 32'(o_imem_req), 32'd1);
    chk("wait_addr6", o_imem_addr, 32'h14);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("valid_after_ack", 32'(o_instr_valid), 32'd1);
    chk("req_low_in_issue", 32'(o_imem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, rbit(50), rbit(50), rbit(50), 0, 0);
      chk("stall_valid", 32'(o_instr_valid), 32'd1);
      chk("stall_pc", o_pc, 32'h14);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("after_stall_addr", o_imem_addr, 32'h18);

    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h400);
    chk("drain_req", 32'(o_imem_req), 32'd1);
    chk("drain_addr_held", o_imem_addr, 32'h18);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("drain_discard", 32'(o_instr_valid), 32'd0);
    chk("drain_next_addr", o_imem_addr, 32'h400);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("redir_target_valid", 32'(o_instr_valid), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("issue_at_40", o_pc, 32'h40);

    #3;
    rst_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    m_presenting = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_instr_valid), 32'd0);
    chk("async_rst_req", 32'(o_imem_req), 32'd0);
    chk("async_rst_pc", o_pc, 32'h0);
    chk("async_rst_instr", o_instr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("restart_req", 32'(o_imem_req), 32'd1);
    chk("restart_addr", o_imem_addr, 32'h0);

    wait_cnt = 0;
    dly = 0;
    held = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      chk("no_req_while_valid", 32'(o_imem_req && o_instr_valid), 32'd0);
      if (o_imem_req) begin
        if (wait_cnt == 0) begin
          dly  = rbit(50) ? 0 : int'($urandom_range(4, 0));
          held = o_imem_addr;
        end else begin
          chk("req_addr_stable", o_imem_addr, held);
        end
        ack = (wait_cnt >= dly);
        wait_cnt = ack ? 0 : wait_cnt + 1;
      end else begin
        ack = rbit(12);
        wait_cnt = 0;
      end
      cyc(ack, rbit(65), rbit(50), rbit(50), rbit(15), rbit(5), $urandom_range(4095, 0));
    end
    chk("progress", 32'(n_presented > 300), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
